sio_dmu_pkt_chk: RTL
====================

Name: sio_dmu_pkt_chk

Overview:
- Synthesizable, parametrised successor to the SIU->DMU outbound packet monitor; sits passively on the sio_dmu_* bus inside the SIO cluster.
- Tracks header and payload framing with an FSM and checks payload parity per byte-group.
- Detects protocol violations: a header arriving during an in-flight packet.
- Exposes saturating packet/error counters, sticky error flags and a captured header for the bench and for on-chip debug.

Parameters:
- DATA_W, 128, width of sio_dmu_data; must be a multiple of PAR_W.
- PAR_W, 8, parity bits per beat; each covers a DATA_W/PAR_W-bit group, bit i covering data[i*G +: G].
- BEATS, 4, payload beats following a header with datareq=1; must be >= 1.
- PAY_DLY, 1, idle cycles between the header cycle and the first payload beat; 0 is allowed.
- ODD_PAR, 0, 0 selects even parity (parity[i] == ^group); 1 selects odd parity (parity[i] == ~^group).
- CNT_W, 16, width of all counters.

Ports:
- iol2clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  checker enable; 0 holds the FSM in IDLE and freezes the counters
- clr  in  1  synchronous clear of counters, sticky flags and last_hdr
- sio_dmu_hdr_vld  in  1  header cycle
- sio_dmu_datareq  in  1  qualifies the header: payload follows
- sio_dmu_data  in  DATA_W  header or payload data
- sio_dmu_parity  in  PAR_W  payload parity
- busy  out  1  FSM not in IDLE
- pkt_done  out  1  one-cycle pulse at packet completion
- pkt_has_pay  out  1  valid with pkt_done; 1 means the packet had a payload
- last_hdr  out  DATA_W  data captured on the last accepted header
- hdr_cnt  out  CNT_W  accepted headers
- pay_cnt  out  CNT_W  completed payload packets
- par_err_cnt  out  CNT_W  beats with at least one parity mismatch
- par_err  out  1  sticky parity error
- proto_err  out  1  sticky protocol error

Behaviour:
- Reset:
  - FSM enters IDLE.
  - All outputs are 0, including last_hdr and all counters.
- FSM states and transitions:
  - IDLE: on hdr_vld && enable, capture last_hdr and increment hdr_cnt.
    - If datareq=1: go to GAP when PAY_DLY>0, otherwise straight to PAY.
    - If datareq=0: pulse pkt_done the next cycle with pkt_has_pay=0 and stay in IDLE.
  - GAP: down-counts PAY_DLY cycles, then moves to PAY.
  - PAY: beat counter runs 0..BEATS-1, one beat per cycle with no stall.
    - Each beat is checked for parity.
    - On the last beat, return to IDLE, pulse pkt_done with pkt_has_pay=1 the following cycle, and increment pay_cnt.
- Latency: pkt_done appears 1 cycle after the last beat, or 1 cycle after the header when there is no payload.
- Default timing: a header at cycle H gives beats at H+2..H+5 and pkt_done at H+6.
- Parity mismatch:
  - Any group mismatch in a PAY beat sets par_err.
  - par_err_cnt increments once per offending beat.
- Protocol error (hdr_vld=1 while in GAP or PAY):
  - Sets proto_err.
  - The new header is ignored; hdr_cnt and last_hdr are unchanged.
  - The current packet continues.
- hdr_vld on the same cycle as the last beat is also a protocol error.
  - Back-to-back headers are legal only from IDLE.
- Counters saturate at all-ones and never wrap.
- clr:
  - Zeroes counters, sticky flags and last_hdr.
  - Does not alter FSM state; an in-flight packet completes normally.
  - If clr coincides with a counter increment, clr wins.
- enable deasserted mid-packet forces IDLE next cycle, with no pkt_done and no pay_cnt increment.
- rst mid-packet forces IDLE immediately; no partial counts are kept.

Optional Feature:
- Macro: SIU_DMU_CHK_LOG_EN.
- When defined, the block prints via PR_ALWAYS/PR_INFO at each event, non-synthesizable:
  - header accepted, including the data
  - payload start
  - each beat's data and parity
  - each parity or protocol error
- When undefined, the block has no display code and is fully synthesizable; behaviour is otherwise identical.

Decomposition:
- Package sio_dmu_chk_pkg holds:
  - FSM state enum (IDLE, GAP, PAY)
  - parity-group width function G = DATA_W/PAR_W
  - saturating-increment function
- Sub-module sio_dmu_par_chk: combinational per-group parity compare, parametrised on DATA_W/PAR_W/ODD_PAR, output a PAR_W mismatch vector.

Test Plan:
- Header with datareq=0, data=0x1234 -> hdr_cnt=1, last_hdr=0x1234, pkt_done at H+1 with pkt_has_pay=0, pay_cnt=0.
- Header with datareq=1 followed by 4 correct even-parity beats -> pkt_done at H+6 with pkt_has_pay=1, pay_cnt=1, par_err=0.
- Payload whose beat 2 has parity bit 3 flipped -> par_err=1, par_err_cnt=1, pay_cnt=1.
- hdr_vld at H+3 during payload -> proto_err=1, hdr_cnt stays 1, original packet completes at H+6.
- CNT_W=2 with 5 no-payload headers -> hdr_cnt saturates at 3; clr pulse -> all counters 0 and flags cleared.
- rst asserted at H+3 mid-payload -> busy=0 immediately, pay_cnt=0, no pkt_done.

Source files
------------

// File: rtl/sio_dmu_pkt_chk_pkg.sv
// rtl/sio_dmu_pkt_chk_pkg.sv - shared types and helpers for the SIU->DMU packet checker
package sio_dmu_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    PAY  = 2'd2
  } state_e;

  function automatic int grp_w(input int data_w, input int par_w);
    return data_w / par_w;
  endfunction

  // Widths up to 32 bits; the value sticks once it reaches all-ones of that width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_v) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/sio_dmu_pkt_chk_if.sv
// rtl/sio_dmu_pkt_chk_if.sv - sio_dmu_* outbound bus as seen by the passive checker
interface sio_dmu_pkt_chk_if #(
  parameter int DATA_W = 128,
  parameter int PAR_W  = 8
);

  logic              sio_dmu_hdr_vld;
  logic              sio_dmu_datareq;
  logic [DATA_W-1:0] sio_dmu_data;
  logic [PAR_W-1:0]  sio_dmu_parity;

  modport master (
    output sio_dmu_hdr_vld,
    output sio_dmu_datareq,
    output sio_dmu_data,
    output sio_dmu_parity
  );

  modport slave (
    input sio_dmu_hdr_vld,
    input sio_dmu_datareq,
    input sio_dmu_data,
    input sio_dmu_parity
  );

endinterface

// File: rtl/sio_dmu_pkt_chk_par.sv
// rtl/sio_dmu_pkt_chk_par.sv - combinational per-group parity compare, one mismatch bit per group
module sio_dmu_par_chk
  import sio_dmu_chk_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int PAR_W   = 8,
  parameter int ODD_PAR = 0
) (
  input  logic [DATA_W-1:0] data,
  input  logic [PAR_W-1:0]  parity,
  output logic [PAR_W-1:0]  mismatch
);

  localparam int   G   = grp_w(DATA_W, PAR_W);
  localparam logic ODD = (ODD_PAR != 0);

  always_comb begin
    mismatch = '0;
    for (int i = 0; i < PAR_W; i++) begin
      mismatch[i] = parity[i] ^ (^data[i*G +: G]) ^ ODD;
    end
  end

endmodule

// File: rtl/sio_dmu_pkt_chk.sv
// rtl/sio_dmu_pkt_chk.sv - passive SIU->DMU packet framing/parity/protocol checker
// Event logging is compiled in only when SIU_DMU_CHK_LOG_EN is defined.
module sio_dmu_pkt_chk
  import sio_dmu_chk_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int PAR_W   = 8,
  parameter int BEATS   = 4,
  parameter int PAY_DLY = 1,
  parameter int ODD_PAR = 0,
  parameter int CNT_W   = 16
) (
  input  logic              iol2clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clr,
  sio_dmu_pkt_chk_if.slave  bus,
  output logic              busy,
  output logic              pkt_done,
  output logic              pkt_has_pay,
  output logic [DATA_W-1:0] last_hdr,
  output logic [CNT_W-1:0]  hdr_cnt,
  output logic [CNT_W-1:0]  pay_cnt,
  output logic [CNT_W-1:0]  par_err_cnt,
  output logic              par_err,
  output logic              proto_err
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int GW = (PAY_DLY > 1) ? $clog2(PAY_DLY) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'((PAY_DLY > 0) ? PAY_DLY - 1 : 0);

  logic              hdr_vld, datareq;
  logic [DATA_W-1:0] data;
  logic [PAR_W-1:0]  parity, mismatch;

  assign hdr_vld = bus.sio_dmu_hdr_vld;
  assign datareq = bus.sio_dmu_datareq;
  assign data    = bus.sio_dmu_data;
  assign parity  = bus.sio_dmu_parity;

  sio_dmu_par_chk #(
    .DATA_W (DATA_W),
    .PAR_W  (PAR_W),
    .ODD_PAR(ODD_PAR)
  ) u_par_chk (
    .data    (data),
    .parity  (parity),
    .mismatch(mismatch)
  );

  state_e            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              pkt_done_q, pkt_done_d;
  logic              has_pay_q, has_pay_d;
  logic [DATA_W-1:0] last_hdr_q, last_hdr_d;
  logic [CNT_W-1:0]  hdr_cnt_q, hdr_cnt_d;
  logic [CNT_W-1:0]  pay_cnt_q, pay_cnt_d;
  logic [CNT_W-1:0]  pec_q, pec_d;
  logic              par_err_q, par_err_d;
  logic              proto_err_q, proto_err_d;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    gap_d       = gap_q;
    pkt_done_d  = 1'b0;
    has_pay_d   = 1'b0;
    last_hdr_d  = last_hdr_q;
    hdr_cnt_d   = hdr_cnt_q;
    pay_cnt_d   = pay_cnt_q;
    pec_d       = pec_q;
    par_err_d   = par_err_q;
    proto_err_d = proto_err_q;

    if (!enable) begin
      state_d = IDLE;
      beat_d  = '0;
      gap_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hdr_vld) begin
            last_hdr_d = data;
            hdr_cnt_d  = CNT_W'(sat_inc(32'(hdr_cnt_q), CNT_W));
            if (datareq) begin
              beat_d = '0;
              if (PAY_DLY > 0) begin
                state_d = GAP;
                gap_d   = GAP_LOAD;
              end else begin
                state_d = PAY;
              end
            end else begin
              pkt_done_d = 1'b1;
            end
          end
        end
        GAP: begin
          if (hdr_vld) proto_err_d = 1'b1;
          if (gap_q == '0) state_d = PAY;
          else             gap_d   = gap_q - GW'(1);
        end
        PAY: begin
          if (hdr_vld) proto_err_d = 1'b1;
          if (|mismatch) begin
            par_err_d = 1'b1;
            pec_d     = CNT_W'(sat_inc(32'(pec_q), CNT_W));
          end
          if (beat_q == LAST_BEAT) begin
            state_d    = IDLE;
            beat_d     = '0;
            pkt_done_d = 1'b1;
            has_pay_d  = 1'b1;
            pay_cnt_d  = CNT_W'(sat_inc(32'(pay_cnt_q), CNT_W));
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // clr wipes the observability state only; the packet in flight carries on.
    if (clr) begin
      last_hdr_d  = '0;
      hdr_cnt_d   = '0;
      pay_cnt_d   = '0;
      pec_d       = '0;
      par_err_d   = 1'b0;
      proto_err_d = 1'b0;
    end
  end

  always_ff @(posedge iol2clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      gap_q       <= '0;
      pkt_done_q  <= 1'b0;
      has_pay_q   <= 1'b0;
      last_hdr_q  <= '0;
      hdr_cnt_q   <= '0;
      pay_cnt_q   <= '0;
      pec_q       <= '0;
      par_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      gap_q       <= gap_d;
      pkt_done_q  <= pkt_done_d;
      has_pay_q   <= has_pay_d;
      last_hdr_q  <= last_hdr_d;
      hdr_cnt_q   <= hdr_cnt_d;
      pay_cnt_q   <= pay_cnt_d;
      pec_q       <= pec_d;
      par_err_q   <= par_err_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign pkt_done    = pkt_done_q;
  assign pkt_has_pay = has_pay_q;
  assign last_hdr    = last_hdr_q;
  assign hdr_cnt     = hdr_cnt_q;
  assign pay_cnt     = pay_cnt_q;
  assign par_err_cnt = pec_q;
  assign par_err     = par_err_q;
  assign proto_err   = proto_err_q;

`ifdef SIU_DMU_CHK_LOG_EN
`ifndef PR_ALWAYS
`define PR_ALWAYS(msg) $display("%0t: %s", $time, msg)
`endif
`ifndef PR_INFO
`define PR_INFO(msg) $display("%0t: %s", $time, msg)
`endif
  always @(posedge iol2clk) begin
    if (!rst && enable) begin
      if (state_q == IDLE && hdr_vld)
        `PR_ALWAYS($sformatf("sio_dmu hdr accepted data=%h datareq=%0b", data, datareq));
      if (state_q == IDLE && hdr_vld && datareq)
        `PR_INFO("sio_dmu payload start");
      if (state_q == PAY)
        `PR_INFO($sformatf("sio_dmu beat %0d data=%h parity=%h", beat_q, data, parity));
      if (state_q == PAY && |mismatch)
        `PR_ALWAYS($sformatf("sio_dmu parity error beat %0d groups=%h", beat_q, mismatch));
      if (state_q != IDLE && hdr_vld)
        `PR_ALWAYS("sio_dmu protocol error: header during packet");
    end
  end
`else
`endif

endmodule
